signed_accum_stage: RTL
=======================

Name: signed_accum_stage

Overview:
- Downstream consumer of the 8-bit two's-complement adder: takes each adder result (sum, overflow_flag) and accumulates a block of results into a wider signed accumulator.
- Uses overflow_flag to recover the true 9-bit result, so adder overflow does not corrupt the running total.
- Presents each completed block total on a valid/ready output handshake.
- Also reports a saturation flag and a count of adder overflows per block.

Parameters:
- WIDTH, 8, adder result width (sum input width).
- ACC_WIDTH, 16, accumulator/output width; must be >= WIDTH+2.
- LEN_WIDTH, 4, width of block_len and of the internal sample counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- enable  input  1  stage enable; 0 freezes all state, in_ready=0, outputs hold.
- block_len  input  LEN_WIDTH  samples per block; latched when a block starts; 0 treated as 1.
- in_valid  input  1  sum/overflow_flag valid.
- in_ready  output  1  stage can accept a sample this cycle.
- sum  input  WIDTH  signed adder result.
- overflow_flag  input  1  adder signed-overflow flag for sum.
- out_valid  output  1  acc_out, acc_sat and ovf_count hold a completed block.
- out_ready  input  1  consumer accepts the block.
- acc_out  output  ACC_WIDTH  signed block total.
- acc_sat  output  1  accumulator saturated during this block (sticky per block).
- ovf_count  output  LEN_WIDTH  number of samples in this block with overflow_flag=1.

Behaviour:
- States: ACCUM and HOLD. Reset enters ACCUM.
- Reset (reset=0 at a clk edge, overrides everything):
  - state=ACCUM; accumulator=0; sample counter=0; len_q=block_len (0 -> 1).
  - out_valid=0, acc_out=0, acc_sat=0, ovf_count=0.
  - An in-flight block is discarded.
- in_ready = enable && state==ACCUM. A sample is accepted when in_valid && in_ready at a clk edge.
- True value per accepted sample:
  - t = {~sum[WIDTH-1], sum} when overflow_flag=1, otherwise {sum[WIDTH-1], sum}.
  - t is (WIDTH+1) bits, sign-extended to ACC_WIDTH.
- Accumulate: nxt = acc + t, computed at ACC_WIDTH+1 bits.
  - If nxt exceeds the signed ACC_WIDTH range, clamp to max (0x7FFF) or min (0x8000) and set acc_sat.
  - acc_sat stays set for the rest of the block.
- ovf_count increments on each accepted sample with overflow_flag=1; it cannot wrap because count <= len_q.
- Sample counter increments per accepted sample.
- Block end, on acceptance of sample number len_q:
  - Next edge: state=HOLD, out_valid=1, acc_out = final total (including that sample), acc_sat and ovf_count final.
  - Latency from last accepted sample to out_valid is 1 cycle.
- HOLD:
  - in_ready=0. acc_out, acc_sat and ovf_count stay stable while out_valid=1 and out_ready=0.
  - When out_valid && out_ready && enable at an edge: out_valid=0, state=ACCUM, accumulator/counter/acc_sat/ovf_count cleared, len_q relatched from block_len.
  - A new sample is accepted no earlier than the cycle after the handoff (no same-cycle bypass).
- block_len changes mid-block have no effect until the next block start.
- enable=0 in any state: no acceptance, no handoff, no state change; reset still acts.
- in_valid while in_ready=0: sample is not consumed; the upstream holds it.

Test Plan:
- Reset/idle: reset=0 for 2 cycles with in_valid=1 -> out_valid=0, acc_out=0, acc_sat=0, ovf_count=0, in_ready=0 during reset, in_ready=1 once reset=1 and enable=1.
- Overflow recovery: block_len=2; samples (sum=0x00, ovf=0) from 1+(-1), then (sum=0x80, ovf=1) from 127+1 -> 1 cycle after 2nd accept: out_valid=1, acc_out=0x0080 (+128), ovf_count=1, acc_sat=0.
- Negative overflow: block_len=1; sum=0x7E, ovf=1 (from -127+-3, true -130) -> acc_out=0xFF7E, ovf_count=1.
- Saturation: block_len=0 (treated as 1) then block_len=15 with 15 samples of sum=0x80, ovf=1 (+128 each, total 1920) -> acc_out=0x0780, acc_sat=0. Rerun with ACC_WIDTH=10 -> acc_out=0x1FF, acc_sat=1.
- Backpressure: complete a block with out_ready=0 for 5 cycles -> out_valid and acc_out stable, in_ready=0. Raise out_ready -> out_valid falls next edge, in_ready=1, next block starts from 0.
- Reset mid-block: accept 1 of 3 samples (+5), pulse reset=0 -> after reset, a 3-sample block of +1 each gives acc_out=3. Also hold enable=0 mid-block for 4 cycles -> no samples consumed, counts unchanged.

Source files
------------

// File: rtl/signed_accum_stage.sv
// signed_accum_stage: accumulates blocks of 8-bit adder results into a wider
// saturating signed total, using the adder's overflow flag to recover the true
// 9-bit value of each sample. Completed block totals leave on a valid/ready
// handshake together with a sticky saturation flag and an overflow count.
module signed_accum_stage #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int LEN_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic        [LEN_WIDTH-1:0] block_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     sum,
    input  logic                        overflow_flag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] acc_out,
    output logic                        acc_sat,
    output logic        [LEN_WIDTH-1:0] ovf_count
);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_t;

    // Rebuild the true adder result: on overflow the stored sign bit is wrong,
    // so the inverted MSB becomes the 9th bit; then sign-extend to ACC_WIDTH.
    function automatic logic signed [ACC_WIDTH-1:0] true_value(
        input logic signed [WIDTH-1:0] s,
        input logic                    ovf
    );
        logic signed [WIDTH:0] t;
        t = {(ovf ? ~s[WIDTH-1] : s[WIDTH-1]), s};
        return {{(ACC_WIDTH-WIDTH-1){t[WIDTH]}}, t};
    endfunction

    // True when a + b falls outside the signed ACC_WIDTH range.
    function automatic logic add_overflows(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        return s[ACC_WIDTH] != s[ACC_WIDTH-1];
    endfunction

    // Saturating a + b: clamps to the signed ACC_WIDTH extremes.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_WIDTH-1:0];
    endfunction

    // A zero block length would never terminate a block; treat it as one.
    function automatic logic [LEN_WIDTH-1:0] norm_len(input logic [LEN_WIDTH-1:0] l);
        return (l == '0) ? LEN_WIDTH'(1) : l;
    endfunction

    state_t                        state_p1, state_nxt;
    logic signed [ACC_WIDTH-1:0]   acc_p1;
    logic                          sat_p1;
    logic        [LEN_WIDTH-1:0]   ovf_p1;
    logic        [LEN_WIDTH-1:0]   cnt_p1;
    logic        [LEN_WIDTH-1:0]   len_p1;

    logic                          accept_p0;
    logic                          handoff_p0;
    logic                          last_p0;
    logic signed [ACC_WIDTH-1:0]   t_p0;

    // ---- stage 0: sample decode and handshake qualification ----
    assign t_p0       = true_value(sum, overflow_flag);
    assign accept_p0  = in_valid && in_ready;
    assign handoff_p0 = (state_p1 == HOLD) && enable && out_ready;
    assign last_p0    = (cnt_p1 == len_p1 - LEN_WIDTH'(1));

    // State register for the ACCUM/HOLD controller.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_p1 <= ACCUM;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    // Next-state and handshake outputs; in_ready is also gated by reset so a
    // sample presented while reset is asserted is never reported as taken.
    always_comb begin
        state_nxt = state_p1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_p1)
            ACCUM: begin
                in_ready = enable && reset;
                if (accept_p0 && last_p0) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (handoff_p0) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // ---- stage 1: accumulator, per-block flags and counters ----
    // Accepted samples update the running block; a handoff clears it and
    // relatches the block length for the next block.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_p1 <= '0;
            sat_p1 <= 1'b0;
            ovf_p1 <= '0;
            cnt_p1 <= '0;
            len_p1 <= norm_len(block_len);
        end else if (accept_p0) begin
            acc_p1 <= sat_add(acc_p1, t_p0);
            sat_p1 <= sat_p1 | add_overflows(acc_p1, t_p0);
            ovf_p1 <= ovf_p1 + LEN_WIDTH'(overflow_flag);
            cnt_p1 <= cnt_p1 + LEN_WIDTH'(1);
        end else if (handoff_p0) begin
            acc_p1 <= '0;
            sat_p1 <= 1'b0;
            ovf_p1 <= '0;
            cnt_p1 <= '0;
            len_p1 <= norm_len(block_len);
        end
    end

    assign acc_out   = acc_p1;
    assign acc_sat   = sat_p1;
    assign ovf_count = ovf_p1;

endmodule
